// File: rtl/disp_scan8.sv
// Eight-digit seven-segment scan controller: IDLE/BLANK/ON rotation over enabled digits.
// Optional DISP_SCAN_BRIGHT_EN adds a 3-bit brightness input that gates an_en within ON.
module disp_scan8 #(
  parameter int unsigned ON_CYC    = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] seg_in,
  input  logic [7:0]  dig_en,
`ifdef DISP_SCAN_BRIGHT_EN
  input  logic [2:0]  bright,
`endif
  output logic [2:0]  an_sel,
  output logic        an_en,
  output logic [7:0]  sseg,
  output logic        frame_tick
);

  localparam int unsigned MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  an_sel_q;
  logic        an_en_q;
  logic [7:0]  sseg_q;
  logic        frame_tick_q;
  logic [2:0]  low_idx;
  logic [2:0]  nxt_idx;

`ifdef DISP_SCAN_BRIGHT_EN
  localparam int unsigned SUB_CYC = ON_CYC / 8;
  // One bit wider than cnt so the full-ON threshold (== ON_CYC) is representable.
  logic [CW:0] thr_q;
`endif

  // Lowest enabled digit, and first enabled digit strictly after the current one (wrapping).
  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (dig_en[7-i]) low_idx = 3'(7 - i);
    end
    nxt_idx = an_sel_q;
    for (int unsigned i = 1; i < 8; i++) begin
      if (dig_en[an_sel_q + 3'(8 - i)]) nxt_idx = an_sel_q + 3'(8 - i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      an_sel_q     <= '0;
      an_en_q      <= 1'b0;
      sseg_q       <= '1;
      frame_tick_q <= 1'b0;
`ifdef DISP_SCAN_BRIGHT_EN
      thr_q        <= '0;
`endif
    end else begin
      frame_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          an_en_q <= 1'b0;
          sseg_q  <= '1;
          cnt_q   <= '0;
          if (|dig_en) begin
            an_sel_q     <= low_idx;
            frame_tick_q <= 1'b1;
            state_q      <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_q   <= '0;
            sseg_q  <= seg_in[{an_sel_q, 3'b000} +: 8];
            an_en_q <= 1'b1;
`ifdef DISP_SCAN_BRIGHT_EN
            thr_q   <= (CW+1)'((int unsigned'(bright) + 1) * SUB_CYC);
`endif
            state_q <= S_ON;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_q   <= '0;
            an_en_q <= 1'b0;
            sseg_q  <= '1;
            if (dig_en == 8'h00) begin
              state_q <= S_IDLE;
            end else begin
              an_sel_q     <= nxt_idx;
              frame_tick_q <= (nxt_idx <= an_sel_q);
              state_q      <= S_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
`ifdef DISP_SCAN_BRIGHT_EN
            an_en_q <= (({1'b0, cnt_q} + (CW+1)'(1)) < thr_q);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign an_sel     = an_sel_q;
  assign an_en      = an_en_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan8.sv
// Scoreboard bench for disp_scan8: slot-position reference model feeds a queue, negedge monitor checks.
module tb_disp_scan8;

  localparam int ON    = 8;
  localparam int BLANK = 2;
  localparam int SLOT  = ON + BLANK;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] seg_in = '0;
  logic [7:0]  dig_en = '0;
`ifdef DISP_SCAN_BRIGHT_EN
  logic [2:0]  bright = 3'd7;
`endif
  logic [2:0]  an_sel;
  logic        an_en;
  logic [7:0]  sseg;
  logic        frame_tick;

  disp_scan8 #(.ON_CYC(ON), .BLANK_CYC(BLANK)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .dig_en(dig_en),
`ifdef DISP_SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .an_sel(an_sel),
    .an_en(an_en),
    .sseg(sseg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic [7:0] sg;
    logic       ft;
  } exp_t;

  localparam exp_t RST_EXP = '{sel: 3'd0, en: 1'b0, sg: 8'hFF, ft: 1'b0};

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: slot position p (0..SLOT-1), digit d, latched pattern.
  bit       scanning = 0;
  int       p = 0;
  int       d = 0;
  int       thr = ON;
  logic [7:0] pat = 8'hFF;

  function automatic int lowest(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int next_after(input int cur, input logic [7:0] m);
    for (int o = 1; o <= 8; o++) if (m[(cur + o) % 8]) return (cur + o) % 8;
    return cur;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   tick;
    int   nd;
    if (reset) begin
      scanning = 0; p = 0; d = 0;
    end else begin
      tick = 0;
      if (!scanning) begin
        if (dig_en != 8'h00) begin
          d = lowest(dig_en); scanning = 1; p = 0; tick = 1;
        end
      end else begin
        p++;
        if (p == BLANK) begin
          pat = seg_in[d*8 +: 8];
`ifdef DISP_SCAN_BRIGHT_EN
          thr = (int'(bright) + 1) * ON / 8;
`else
          thr = ON;
`endif
        end
        if (p == SLOT) begin
          if (dig_en == 8'h00) begin
            scanning = 0;
          end else begin
            nd = next_after(d, dig_en);
            tick = (nd <= d);
            d = nd; p = 0;
          end
        end
      end
      e.sel = 3'(d);
      e.en  = scanning && (p >= BLANK) && ((p - BLANK) < thr);
      e.sg  = (scanning && p >= BLANK) ? pat : 8'hFF;
      e.ft  = tick;
      sb.push_back(e);
    end
  end

  // Monitor: compares once per cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t got, e;
    #1;
    got = '{sel: an_sel, en: an_en, sg: sseg, ft: frame_tick};
    if (reset) begin
      n_checks++;
      if (got !== RST_EXP) begin
        n_fail++;
        $display("FAIL reset_hold t=%0t got sel=%0d en=%b sseg=%h ft=%b want sel=0 en=0 sseg=ff ft=0",
                 $time, got.sel, got.en, got.sg, got.ft);
      end
    end else if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle t=%0t got sel=%0d en=%b sseg=%h ft=%b want sel=%0d en=%b sseg=%h ft=%b",
                 $time, got.sel, got.en, got.sg, got.ft, e.sel, e.en, e.sg, e.ft);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(RST_EXP);
  endtask

  task automatic wait_lit(input int want_sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an_en && (want_sel < 0 || int'(an_sel) == want_sel)) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_lit_timeout sel=%0d", want_sel);
  endtask

  task automatic reset_pulse();
    exp_t got;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    got = '{sel: an_sel, en: an_en, sg: sseg, ft: frame_tick};
    n_checks++;
    if (got !== RST_EXP) begin
      n_fail++;
      $display("FAIL reset_immediate got sel=%0d en=%b sseg=%h ft=%b want sel=0 en=0 sseg=ff ft=0",
               got.sel, got.en, got.sg, got.ft);
    end
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] rand_mask();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'(1 << $urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    release_reset();
    repeat (20) @(negedge clk);

    // Full rotation: byte k = k
    for (int k = 0; k < 8; k++) seg_in[k*8 +: 8] = 8'(k);
    dig_en = 8'hFF;
    repeat (170) @(negedge clk);

    // Reset mid-ON, then idle with an empty mask
    wait_lit(-1);
    reset_pulse();
    dig_en = 8'h00;
    release_reset();
    repeat (25) @(negedge clk);

    // Sparse mask
    dig_en = 8'b1000_0100;
    repeat (60) @(negedge clk);

    // Single digit, then disable mid-ON
    dig_en = 8'h08;
    repeat (35) @(negedge clk);
    wait_lit(3);
    repeat (2) @(negedge clk);
    dig_en = 8'h00;
    repeat (25) @(negedge clk);

    // Mid-slot data change on digit 0
    seg_in[7:0] = 8'hC0;
    dig_en = 8'h03;
    wait_lit(0);
    repeat (2) @(negedge clk);
    seg_in[7:0] = 8'hF9;
    repeat (45) @(negedge clk);

`ifdef DISP_SCAN_BRIGHT_EN
    dig_en = 8'h08;
    bright = 3'd1;
    repeat (40) @(negedge clk);
    bright = 3'd7;
    repeat (30) @(negedge clk);
`endif

    // Randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) dig_en = rand_mask();
      if ($urandom_range(0, 9) == 0)  seg_in = {$urandom, $urandom};
`ifdef DISP_SCAN_BRIGHT_EN
      if ($urandom_range(0, 19) == 0) bright = 3'($urandom);
`endif
      if (c == 700) begin
        reset_pulse();
        release_reset();
      end
    end
    repeat (2) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/disp_scan8.md
# disp_scan8

Time-multiplexed scan controller for an eight-digit seven-segment display. It sequences the 3-to-8 anode decoder by driving its 3-bit select and its enable, and it presents the segment pattern of the selected digit. A per-digit enable mask removes digits from the rotation. A blanking interval between digits suppresses ghosting. The block sits between the display-data registers and the anode decoder and segment pins.

## Interface
- `ON_CYC`, default 50000: clock cycles a digit is lit per slot; ≥1; multiple of 8 when `DISP_SCAN_BRIGHT_EN` is defined.
- `BLANK_CYC`, default 1000: dead cycles before each lit phase; ≥1.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `seg_in` in 64: segment patterns, active-low; digit k at [8k+7:8k], bit 7 = dp.
- `dig_en` in 8: digit k participates in the scan when bit k = 1.
- `bright` in 3: brightness level; present only with `DISP_SCAN_BRIGHT_EN`.
- `an_sel` out 3: decoder select, i.e. the current digit index.
- `an_en` out 1: decoder enable; 1 only while the digit is lit.
- `sseg` out 8: segment output, active-low; 8'hFF when blanked.
- `frame_tick` out 1: one-cycle pulse at the start of each scan frame.

## Operation
- Three states: IDLE, BLANK, ON. A cycle counter `cnt` is sized to max(`ON_CYC`, `BLANK_CYC`).
- **Reset.** State is IDLE. `cnt`=0, `an_sel`=0, `an_en`=0, `sseg`=8'hFF, `frame_tick`=0.
- **IDLE.** `an_en`=0 and `sseg`=8'hFF.
  - If `dig_en`≠0: `an_sel` ← lowest set index; go to BLANK with `frame_tick`=1 for that cycle.
- **BLANK.** `an_en`=0 and `sseg`=8'hFF for `BLANK_CYC` cycles.
  - On the final cycle: `sseg` ← `seg_in[8·an_sel+:8]`; go to ON.
- **ON.** `an_en`=1 and `sseg` holds the latched pattern for `ON_CYC` cycles.
  - `seg_in` changes during ON are not shown until the next slot.
- **End of ON**, with `dig_en` sampled on the final ON cycle:
  - If `dig_en`=0: go to IDLE; `an_en`=0 and `sseg`=8'hFF.
  - Otherwise: `an_sel` ← the next set index strictly after the current one, wrapping 7→0. With only the current digit set, the index is unchanged.
  - Go to BLANK. `frame_tick`=1 on the first BLANK cycle when the new index ≤ the old index (wrap).
- **Mask changes.**
  - A change to `dig_en` mid-slot never truncates the slot. The current digit completes even if it has just been disabled.
  - A change during BLANK or ON affects only the next selection.
- **Reset mid-slot.** Outputs return to reset values immediately (asynchronous). The scan restarts from IDLE.
- `an_sel` changes only while `an_en`=0, so the decoder never glitches between two lit digits.

## Timing
- Slot period is `BLANK_CYC`+`ON_CYC` cycles. Frame period is slot period × popcount(`dig_en`).
- IDLE→BLANK latency: `an_sel` becomes valid 1 cycle after `dig_en` goes nonzero.
- `an_en` rises `BLANK_CYC` cycles after BLANK is entered.
- All outputs are registered, with no combinational path from inputs to outputs.
- `frame_tick` is exactly 1 cycle wide. Its coincident `an_sel` is the first digit of the frame.

## Configuration
- **`DISP_SCAN_BRIGHT_EN` defined:**
  - Adds the `bright` port. ON is divided into 8 equal sub-phases.
  - `an_en`=1 only while the ON count is < (`bright`+1)·`ON_CYC`/8. `sseg` stays latched for the whole of ON.
  - `bright` is sampled at BLANK→ON.
  - `bright`=7 gives identical behaviour to the build without the macro.
- **Not defined:** no `bright` port; `an_en`=1 for all of ON.

## Test plan
Parameters for all scenarios: `ON_CYC`=8, `BLANK_CYC`=2.
- **Reset and idle.** Assert `reset` mid-ON with `dig_en`=8'hFF.
  - Required: `an_en`=0, `sseg`=FF, `an_sel`=0 in the same cycle.
  - After release with `dig_en`=0: outputs hold these values indefinitely.
- **Full rotation.** `dig_en`=8'hFF, `seg_in` byte k = k.
  - Required: `an_sel` steps 0..7 then 0, each slot 10 cycles, with 2 blank then 8 lit.
  - `sseg`=k while lit. `frame_tick` pulses every 80 cycles with `an_sel`=0.
- **Sparse mask.** `dig_en`=8'b1000_0100.
  - Required: `an_sel` alternates 2,7,2,7. `frame_tick` on every entry to 2; period 20 cycles.
- **Single digit and disable.** Start with `dig_en`=8'h08.
  - Required: `an_sel` stays 3 and `frame_tick` fires every slot.
  - Clear `dig_en` at ON cycle 3: the slot finishes all 8 lit cycles, then IDLE with `an_en`=0.
- **Mid-slot data change.** Change `seg_in` byte 0 from 8'hC0 to 8'hF9 during ON of digit 0.
  - Required: `sseg` stays C0 until the slot ends; the next digit-0 slot shows F9.
- **Brightness (macro defined).** `bright`=1, single digit.
  - Required: `an_en` high for 2 of every 8 ON cycles, low for the other 6 plus the 2 blank cycles.
  - `bright`=7: high for all 8 ON cycles.
